id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX operand select feeding the ALU (ALUCtl, a, b).
//  Captures decoded control and register-file operands once per cycle, supports stall and flush,
//  resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and presents final a/b to the ALU.
// PARAMETERS
//  ALU_INSTRUCTION_WIDTH  4   width of ALU control code
//  XLEN                   32  datapath width
//  REG_ADDR_W             5   register index width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        synchronous, active-low reset
//  stall         in   1        hold all ID/EX state
//  flush         in   1        insert bubble (priority over stall)
//  id_valid      in   1        decode slot holds a real instruction
//  id_alu_ctl    in   ALU_W    decoded ALU control code
//  id_rs1_addr   in   REG_ADDR_W  source 1 index
//  id_rs2_addr   in   REG_ADDR_W  source 2 index
//  id_rd_addr    in   REG_ADDR_W  destination index
//  id_rs1_data   in   XLEN     register-file read 1
//  id_rs2_data   in   XLEN     register-file read 2
//  id_imm        in   XLEN     sign-extended immediate
//  id_pc         in   XLEN     instruction PC
//  id_use_imm    in   1        b := imm instead of rs2
//  id_use_pc     in   1        a := pc instead of rs1
//  id_reg_write  in   1        instruction writes rd
//  id_is_branch  in   1        conditional branch (ALU Zero consumed)
//  exm_reg_write in   1        EX/MEM writes rd;   exm_rd_addr in REG_ADDR_W;  exm_alu_o in XLEN
//  wb_reg_write  in   1        MEM/WB writes rd;   wb_rd_addr  in REG_ADDR_W;  wb_data   in XLEN
//  ex_valid      out  1        EX slot valid
//  ex_alu_ctl    out  ALU_W    to ALU ALUCtl
//  ex_a, ex_b    out  XLEN     to ALU a, b
//  ex_store_data out  XLEN     forwarded rs2 (store data)
//  ex_pc         out  XLEN     PC for branch target
//  ex_rd_addr    out  REG_ADDR_W; ex_reg_write out 1; ex_is_branch out 1
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): every registered field 0; ex_valid/ex_reg_write/ex_is_branch=0,
//    ex_alu_ctl=0, so ex_a/ex_b/ex_store_data/ex_pc read 0.
//  - Latency 1 cycle ID->EX register; operand select/forward combinational in EX cycle.
//  - Edge priority: reset > flush > stall > capture.
//  - flush: ex_valid, ex_reg_write, ex_is_branch <= 0; ex_alu_ctl <= ALU_ADD; data fields don't-care (hold).
//  - stall (no flush): control fields hold; held rs1/rs2 values refreshed from wb_data when
//    wb_reg_write & wb_rd_addr!=0 & addr match (value would otherwise retire during stall).
//  - capture: all id_* registered; id_valid=0 forces reg_write/is_branch to 0.
//    Write-through: if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==id_rsN_addr, capture wb_data not id_rsN_data.
//  - Forward (per operand, on registered rsN): EX/MEM match -> exm_alu_o; else MEM/WB match -> wb_data;
//    else registered value. Match requires *_reg_write=1 and rd!=0; x0 never forwarded; EX/MEM wins ties.
//  - ex_a = use_pc ? pc : fwd_rs1;  ex_b = use_imm ? imm : fwd_rs2;  ex_store_data = fwd_rs2 always.
//  - Load-use hazards are not detected here; upstream asserts stall/flush.
// CONFIGURATION
//  FWD_EN defined: forwarding + stall refresh + write-through active as above.
//  FWD_EN undefined: exm_*/wb_* inputs ignored; operands come only from registered values;
//    upstream hazard unit must stall until writeback completes. Reset/stall/flush unchanged.
// STRUCTURE
//  Shared package alu_pkg: ALU_* control codes, ALU_W, fwd_sel_t enum {FWD_NONE, FWD_EXM, FWD_WB}.
//  Sub-module fwd_mux (instantiated twice): rs addr/data + EX/MEM + MEM/WB -> fwd_sel_t, value.
// TESTING
//  - Reset: rst_n=0 one cycle with id_valid=1 -> all outputs 0 next cycle.
//  - Forward: EX/MEM rd=5 exm_alu_o=0x10, ID rs1=5 rs1_data=0x3, ADD -> ex_a=0x10.
//  - Tie/x0: exm and wb both rd=7 (0xAA vs 0xBB) -> ex_b=0xAA; rd=0 writes never forwarded -> raw value.
//  - Stall refresh: stall 2 cycles, wb writes rd=3=0x55 while held rs2=3 -> after release ex_store_data=0x55.
//  - Flush+stall same edge: valid instr in ID -> ex_valid=0, ex_reg_write=0, ex_alu_ctl=ALU_ADD.
//  - Mux: use_pc=1, use_imm=1, pc=0x100, imm=-4 -> ex_a=0x100, ex_b=0xFFFFFFFC; with FWD_EN off, forward case gives 0x3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and the operand-forwarding select type shared
// by the EX-stage operand logic.
package alu_pkg;

   // Width of the ALU control code driven into the ALU's ALUCtl input.
   localparam int unsigned ALU_W = 4;

   // ALU control encodings (classic ALUCtl assignment).
   localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

   // Where an EX operand is taken from.
   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,  // registered ID/EX value
      FWD_EXM  = 2'd1,  // EX/MEM ALU result
      FWD_WB   = 2'd2   // MEM/WB write-back data
   } fwd_sel_t;

endpackage : alu_pkg

// File: rtl/fwd_mux.sv
// fwd_mux: per-operand RAW forwarding select. The EX/MEM result wins over
// MEM/WB because it is the younger write; register x0 is never forwarded.
module fwd_mux
   import alu_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic [XLEN-1:0]       rs_data_i,
   input  logic                  exm_reg_write_i,
   input  logic [REG_ADDR_W-1:0] exm_rd_addr_i,
   input  logic [XLEN-1:0]       exm_alu_i,
   input  logic                  wb_reg_write_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
   input  logic [XLEN-1:0]       wb_data_i,
   output fwd_sel_t              fwd_sel_o,
   output logic [XLEN-1:0]       fwd_data_o
);

   logic exm_hit;
   logic wb_hit;

   // Detect a pending write to the source register in each later stage.
   always_comb begin
      exm_hit = exm_reg_write_i && (exm_rd_addr_i != '0) && (exm_rd_addr_i == rs_addr_i);
      wb_hit  = wb_reg_write_i  && (wb_rd_addr_i  != '0) && (wb_rd_addr_i  == rs_addr_i);
   end

   // Prioritise the youngest producer.
   always_comb begin
      fwd_sel_o = FWD_NONE;
      if (exm_hit) begin
         fwd_sel_o = FWD_EXM;
      end else if (wb_hit) begin
         fwd_sel_o = FWD_WB;
      end
   end

   // Steer the selected source onto the operand.
   always_comb begin
      fwd_data_o = rs_data_i;
      case (fwd_sel_o)
         FWD_EXM: fwd_data_o = exm_alu_i;
         FWD_WB:  fwd_data_o = wb_data_i;
         default: fwd_data_o = rs_data_i;
      endcase
   end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand select for the ALU.
// Edge priority is reset > flush > stall > capture.
// Build option: define FWD_EN to enable EX/MEM and MEM/WB forwarding, stall
// refresh of held operands and register-file write-through on capture.
// Without FWD_EN operands come only from the registered values.
module id_ex_stage
   import alu_pkg::*;
#(
   parameter int unsigned ALU_INSTRUCTION_WIDTH = 4,
   parameter int unsigned XLEN                  = 32,
   parameter int unsigned REG_ADDR_W            = 5
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             stall,
   input  logic                             flush,
   input  logic                             id_valid,
   input  logic [ALU_INSTRUCTION_WIDTH-1:0] id_alu_ctl,
   input  logic [REG_ADDR_W-1:0]            id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]            id_rs2_addr,
   input  logic [REG_ADDR_W-1:0]            id_rd_addr,
   input  logic [XLEN-1:0]                  id_rs1_data,
   input  logic [XLEN-1:0]                  id_rs2_data,
   input  logic [XLEN-1:0]                  id_imm,
   input  logic [XLEN-1:0]                  id_pc,
   input  logic                             id_use_imm,
   input  logic                             id_use_pc,
   input  logic                             id_reg_write,
   input  logic                             id_is_branch,
   input  logic                             exm_reg_write,
   input  logic [REG_ADDR_W-1:0]            exm_rd_addr,
   input  logic [XLEN-1:0]                  exm_alu_o,
   input  logic                             wb_reg_write,
   input  logic [REG_ADDR_W-1:0]            wb_rd_addr,
   input  logic [XLEN-1:0]                  wb_data,
   output logic                             ex_valid,
   output logic [ALU_INSTRUCTION_WIDTH-1:0] ex_alu_ctl,
   output logic [XLEN-1:0]                  ex_a,
   output logic [XLEN-1:0]                  ex_b,
   output logic [XLEN-1:0]                  ex_store_data,
   output logic [XLEN-1:0]                  ex_pc,
   output logic [REG_ADDR_W-1:0]            ex_rd_addr,
   output logic                             ex_reg_write,
   output logic                             ex_is_branch
);

   localparam logic [ALU_INSTRUCTION_WIDTH-1:0] ALU_ADD_CODE = ALU_INSTRUCTION_WIDTH'(ALU_ADD);

   // ID/EX register fields
   logic                             valid_q,     valid_d;
   logic [ALU_INSTRUCTION_WIDTH-1:0] alu_ctl_q,   alu_ctl_d;
   logic [REG_ADDR_W-1:0]            rs1_addr_q,  rs1_addr_d;
   logic [REG_ADDR_W-1:0]            rs2_addr_q,  rs2_addr_d;
   logic [REG_ADDR_W-1:0]            rd_addr_q,   rd_addr_d;
   logic [XLEN-1:0]                  rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0]                  rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0]                  imm_q,       imm_d;
   logic [XLEN-1:0]                  pc_q,        pc_d;
   logic                             use_imm_q,   use_imm_d;
   logic                             use_pc_q,    use_pc_d;
   logic                             reg_write_q, reg_write_d;
   logic                             is_branch_q, is_branch_d;

   // Write-back hits used for capture write-through and stall refresh
   logic wb_hit_id_rs1;
   logic wb_hit_id_rs2;
   logic wb_hit_ex_rs1;
   logic wb_hit_ex_rs2;

   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   fwd_sel_t        fwd_sel_rs1;
   fwd_sel_t        fwd_sel_rs2;

   // Compare the MEM/WB destination against incoming and held source indices.
   always_comb begin
      wb_hit_id_rs1 = 1'b0;
      wb_hit_id_rs2 = 1'b0;
      wb_hit_ex_rs1 = 1'b0;
      wb_hit_ex_rs2 = 1'b0;
`ifdef FWD_EN
      if (wb_reg_write && (wb_rd_addr != '0)) begin
         wb_hit_id_rs1 = (wb_rd_addr == id_rs1_addr);
         wb_hit_id_rs2 = (wb_rd_addr == id_rs2_addr);
         wb_hit_ex_rs1 = (wb_rd_addr == rs1_addr_q);
         wb_hit_ex_rs2 = (wb_rd_addr == rs2_addr_q);
      end
`endif
   end

   // Next-state selection: flush, else stall (hold + refresh), else capture.
   always_comb begin
      valid_d     = valid_q;
      alu_ctl_d   = alu_ctl_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      use_imm_d   = use_imm_q;
      use_pc_d    = use_pc_q;
      reg_write_d = reg_write_q;
      is_branch_d = is_branch_q;

      if (flush) begin
         // Bubble: kill side effects, data fields keep their old contents.
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         is_branch_d = 1'b0;
         alu_ctl_d   = ALU_ADD_CODE;
      end else if (stall) begin
         // A value retiring while we are held would otherwise be lost once
         // it leaves MEM/WB, so pull it into the held operand now.
         if (wb_hit_ex_rs1) begin
            rs1_data_d = wb_data;
         end
         if (wb_hit_ex_rs2) begin
            rs2_data_d = wb_data;
         end
      end else begin
         valid_d     = id_valid;
         alu_ctl_d   = id_alu_ctl;
         rs1_addr_d  = id_rs1_addr;
         rs2_addr_d  = id_rs2_addr;
         rd_addr_d   = id_rd_addr;
         rs1_data_d  = wb_hit_id_rs1 ? wb_data : id_rs1_data;
         rs2_data_d  = wb_hit_id_rs2 ? wb_data : id_rs2_data;
         imm_d       = id_imm;
         pc_d        = id_pc;
         use_imm_d   = id_use_imm;
         use_pc_d    = id_use_pc;
         reg_write_d = id_reg_write & id_valid;
         is_branch_d = id_is_branch & id_valid;
      end
   end

   // ID/EX pipeline register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         alu_ctl_q   <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         use_imm_q   <= 1'b0;
         use_pc_q    <= 1'b0;
         reg_write_q <= 1'b0;
         is_branch_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         alu_ctl_q   <= alu_ctl_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         use_imm_q   <= use_imm_d;
         use_pc_q    <= use_pc_d;
         reg_write_q <= reg_write_d;
         is_branch_q <= is_branch_d;
      end
   end

`ifdef FWD_EN
   logic exm_we_fwd;
   logic wb_we_fwd;
   assign exm_we_fwd = exm_reg_write;
   assign wb_we_fwd  = wb_reg_write;
`else
   // Later-stage writes are never forwarded; the hazard unit stalls instead.
   logic exm_we_fwd;
   logic wb_we_fwd;
   logic unused_fwd_we;
   assign exm_we_fwd    = 1'b0;
   assign wb_we_fwd     = 1'b0;
   assign unused_fwd_we = exm_reg_write ^ wb_reg_write;
`endif

   fwd_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_rs1 (
      .rs_addr_i       (rs1_addr_q),
      .rs_data_i       (rs1_data_q),
      .exm_reg_write_i (exm_we_fwd),
      .exm_rd_addr_i   (exm_rd_addr),
      .exm_alu_i       (exm_alu_o),
      .wb_reg_write_i  (wb_we_fwd),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_data_i       (wb_data),
      .fwd_sel_o       (fwd_sel_rs1),
      .fwd_data_o      (fwd_rs1)
   );

   fwd_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_rs2 (
      .rs_addr_i       (rs2_addr_q),
      .rs_data_i       (rs2_data_q),
      .exm_reg_write_i (exm_we_fwd),
      .exm_rd_addr_i   (exm_rd_addr),
      .exm_alu_i       (exm_alu_o),
      .wb_reg_write_i  (wb_we_fwd),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_data_i       (wb_data),
      .fwd_sel_o       (fwd_sel_rs2),
      .fwd_data_o      (fwd_rs2)
   );

   // The select codes are only informative here; the data already reflects them.
   logic unused_fwd_sel;
   assign unused_fwd_sel = ^{fwd_sel_rs1, fwd_sel_rs2};

   // EX operand select and registered outputs.
   always_comb begin
      ex_valid      = valid_q;
      ex_alu_ctl    = alu_ctl_q;
      ex_a          = use_pc_q  ? pc_q  : fwd_rs1;
      ex_b          = use_imm_q ? imm_q : fwd_rs2;
      ex_store_data = fwd_rs2;
      ex_pc         = pc_q;
      ex_rd_addr    = rd_addr_q;
      ex_reg_write  = reg_write_q;
      ex_is_branch  = is_branch_q;
   end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic for id_ex_stage,
// checked against a transaction-level model of the EX slot. Follows the
// FWD_EN build option of the design.
module tb_id_ex_stage;
   import alu_pkg::*;

`ifdef FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, id_valid;
   logic [3:0]  id_alu_ctl;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic        id_use_imm, id_use_pc, id_reg_write, id_is_branch;
   logic        exm_reg_write, wb_reg_write;
   logic [4:0]  exm_rd_addr, wb_rd_addr;
   logic [31:0] exm_alu_o, wb_data;
   logic        ex_valid, ex_reg_write, ex_is_branch;
   logic [3:0]  ex_alu_ctl;
   logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
   logic [4:0]  ex_rd_addr;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Instruction currently occupying the EX slot, as the model sees it.
   typedef struct {
      logic        valid;
      logic [3:0]  alu;
      logic [4:0]  rs1a, rs2a, rd;
      logic [31:0] rs1d, rs2d, imm, pc;
      logic        use_imm, use_pc, rw, br;
   } ex_t;
   ex_t m;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .id_valid      (id_valid),
      .id_alu_ctl    (id_alu_ctl),
      .id_rs1_addr   (id_rs1_addr),
      .id_rs2_addr   (id_rs2_addr),
      .id_rd_addr    (id_rd_addr),
      .id_rs1_data   (id_rs1_data),
      .id_rs2_data   (id_rs2_data),
      .id_imm        (id_imm),
      .id_pc         (id_pc),
      .id_use_imm    (id_use_imm),
      .id_use_pc     (id_use_pc),
      .id_reg_write  (id_reg_write),
      .id_is_branch  (id_is_branch),
      .exm_reg_write (exm_reg_write),
      .exm_rd_addr   (exm_rd_addr),
      .exm_alu_o     (exm_alu_o),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_data       (wb_data),
      .ex_valid      (ex_valid),
      .ex_alu_ctl    (ex_alu_ctl),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_store_data (ex_store_data),
      .ex_pc         (ex_pc),
      .ex_rd_addr    (ex_rd_addr),
      .ex_reg_write  (ex_reg_write),
      .ex_is_branch  (ex_is_branch)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Value the register file will hold for addr once the given write lands.
   function automatic logic [31:0] wb_visible(input logic [4:0] addr, input logic [31:0] old);
      if (FWD && wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == addr) return wb_data;
      return old;
   endfunction

   // Newest architectural value of a source register seen from EX.
   function automatic logic [31:0] newest(input logic [4:0] addr, input logic [31:0] old);
      if (FWD && exm_reg_write && exm_rd_addr != 0 && exm_rd_addr == addr) return exm_alu_o;
      return wb_visible(addr, old);
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m = '{valid: 1'b0, alu: 4'd0, rs1a: 5'd0, rs2a: 5'd0, rd: 5'd0,
               rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0, pc: 32'd0,
               use_imm: 1'b0, use_pc: 1'b0, rw: 1'b0, br: 1'b0};
      end else if (flush) begin
         m.valid = 1'b0; m.rw = 1'b0; m.br = 1'b0; m.alu = ALU_ADD;
      end else if (stall) begin
         m.rs1d = wb_visible(m.rs1a, m.rs1d);
         m.rs2d = wb_visible(m.rs2a, m.rs2d);
      end else begin
         m.valid = id_valid;        m.alu = id_alu_ctl;
         m.rs1a = id_rs1_addr;      m.rs2a = id_rs2_addr;   m.rd = id_rd_addr;
         m.rs1d = wb_visible(id_rs1_addr, id_rs1_data);
         m.rs2d = wb_visible(id_rs2_addr, id_rs2_data);
         m.imm = id_imm;            m.pc = id_pc;
         m.use_imm = id_use_imm;    m.use_pc = id_use_pc;
         m.rw = id_reg_write && id_valid;
         m.br = id_is_branch && id_valid;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] op1, op2;
      op1 = newest(m.rs1a, m.rs1d);
      op2 = newest(m.rs2a, m.rs2d);
      check_eq("ex_valid",      32'(ex_valid),      32'(m.valid));
      check_eq("ex_alu_ctl",    32'(ex_alu_ctl),    32'(m.alu));
      check_eq("ex_a",          ex_a,               m.use_pc ? m.pc : op1);
      check_eq("ex_b",          ex_b,               m.use_imm ? m.imm : op2);
      check_eq("ex_store_data", ex_store_data,      op2);
      check_eq("ex_pc",         ex_pc,              m.pc);
      check_eq("ex_rd_addr",    32'(ex_rd_addr),    32'(m.rd));
      check_eq("ex_reg_write",  32'(ex_reg_write),  32'(m.rw));
      check_eq("ex_is_branch",  32'(ex_is_branch),  32'(m.br));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle();
      rst_n = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      id_alu_ctl = ALU_ADD; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
      id_use_imm = 1'b0; id_use_pc = 1'b0; id_reg_write = 1'b0; id_is_branch = 1'b0;
      exm_reg_write = 1'b0; exm_rd_addr = '0; exm_alu_o = '0;
      wb_reg_write = 1'b0; wb_rd_addr = '0; wb_data = '0;
   endtask

   task automatic drive_random();
      rst_n         = ($urandom_range(0, 31) != 0);
      flush         = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      id_valid      = 1'($urandom);
      id_alu_ctl    = 4'($urandom);
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rd_addr    = 5'($urandom);
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_pc         = $urandom;
      id_use_imm    = 1'($urandom);
      id_use_pc     = 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_is_branch  = 1'($urandom);
      exm_reg_write = 1'($urandom);
      exm_rd_addr   = 5'($urandom_range(0, 7));
      exm_alu_o     = $urandom;
      wb_reg_write  = 1'($urandom);
      wb_rd_addr    = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
   endtask

   initial begin
      idle();

      // Reset with a live instruction in decode: everything reads 0.
      rst_n = 1'b0; id_valid = 1'b1; id_reg_write = 1'b1; id_is_branch = 1'b1;
      id_alu_ctl = ALU_SUB; id_rs1_data = 32'h1234; id_pc = 32'h40; id_rd_addr = 5'd9;
      tick();
      check_eq("rst_valid", 32'(ex_valid), 32'd0);
      check_eq("rst_alu",   32'(ex_alu_ctl), 32'd0);
      check_eq("rst_a",     ex_a, 32'd0);
      check_eq("rst_pc",    ex_pc, 32'd0);

      // EX/MEM forward onto rs1.
      @(negedge clk); idle();
      id_valid = 1'b1; id_alu_ctl = ALU_ADD; id_rs1_addr = 5'd5; id_rs1_data = 32'h3;
      exm_reg_write = 1'b1; exm_rd_addr = 5'd5; exm_alu_o = 32'h10;
      tick();
      check_eq("fwd_exm_a", ex_a, FWD ? 32'h10 : 32'h3);

      // EX/MEM and MEM/WB both target rs2: the younger EX/MEM value wins.
      @(negedge clk); idle();
      id_valid = 1'b1; id_rs2_addr = 5'd7; id_rs2_data = 32'h1234;
      exm_reg_write = 1'b1; exm_rd_addr = 5'd7; exm_alu_o = 32'hAA;
      wb_reg_write = 1'b1;  wb_rd_addr = 5'd7;  wb_data = 32'hBB;
      tick();
      check_eq("tie_b", ex_b, FWD ? 32'hAA : 32'h1234);

      // Writes to x0 are never forwarded.
      @(negedge clk); idle();
      id_valid = 1'b1; id_rs2_addr = 5'd0; id_rs2_data = 32'h77;
      exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_alu_o = 32'hAA;
      wb_reg_write = 1'b1;  wb_rd_addr = 5'd0;  wb_data = 32'hBB;
      tick();
      check_eq("x0_b", ex_b, 32'h77);

      // Held rs2 picks up a write-back that retires during a 2-cycle stall.
      @(negedge clk); idle();
      id_valid = 1'b1; id_rs2_addr = 5'd3; id_rs2_data = 32'h11; id_reg_write = 1'b1;
      tick();
      @(negedge clk);
      id_valid = 1'b0; stall = 1'b1;
      wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'h55;
      tick();
      tick();
      @(negedge clk);
      stall = 1'b0; wb_reg_write = 1'b0; wb_data = 32'h0;
      #1;
      check_eq("stall_refresh", ex_store_data, FWD ? 32'h55 : 32'h11);
      check_eq("stall_hold_rw", 32'(ex_reg_write), 32'd1);

      // Flush beats stall on the same edge.
      @(negedge clk); idle();
      id_valid = 1'b1; id_reg_write = 1'b1; id_is_branch = 1'b1; id_alu_ctl = ALU_SUB;
      flush = 1'b1; stall = 1'b1;
      tick();
      check_eq("flush_valid", 32'(ex_valid), 32'd0);
      check_eq("flush_rw",    32'(ex_reg_write), 32'd0);
      check_eq("flush_alu",   32'(ex_alu_ctl), 32'(ALU_ADD));

      // PC and immediate operand select.
      @(negedge clk); idle();
      id_valid = 1'b1; id_use_pc = 1'b1; id_use_imm = 1'b1;
      id_pc = 32'h100; id_imm = 32'hFFFF_FFFC; id_rs1_data = 32'h9; id_rs2_data = 32'h8;
      tick();
      check_eq("mux_a", ex_a, 32'h100);
      check_eq("mux_b", ex_b, 32'hFFFF_FFFC);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         drive_random();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_id_ex_stage
